// File: rtl/adat_rx_frame_assembler.sv
// ADAT receive frame assembler: gathers channels 0..7 into a shadow buffer and publishes whole frames.
// Optional macro ADAT_RX_FRAME_CNT_EN adds a 16-bit published-frame counter on o_frame_count.
module adat_rx_frame_assembler (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [23:0]  i_data,
  input  logic [2:0]   i_channel,
  input  logic         i_data_valid,
  input  logic [3:0]   i_user,
  input  logic         i_sync,
  output logic [191:0] o_samples,
  output logic [3:0]   o_user,
  output logic         o_frame_valid,
  input  logic         i_frame_ready,
  output logic         o_overrun,
  output logic         o_seq_err
`ifdef ADAT_RX_FRAME_CNT_EN
  ,output logic [15:0] o_frame_count
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DISCARD} state_t;

  state_t        state_q;
  logic [2:0]    expected_q;
  logic [23:0]   shadow_q [8];
  logic [3:0]    user_cap_q;
  logic [191:0]  samples_q;
  logic [3:0]    user_q;
  logic          frame_valid_q;
  logic          overrun_q;
  logic          seq_err_q;

  logic          word_q_valid;
  logic          in_seq_d;
  logic          seq_err_d;
  logic          last_d;
  logic          publish_d;
  logic          overrun_d;
  logic [191:0]  frame_word;

  // Channel 7 bypasses the shadow so the frame publishes on the same edge it arrives.
  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_pack
      assign frame_word[24*gi +: 24] = shadow_q[gi];
    end
  endgenerate
  assign frame_word[191:168] = i_data;

  always_comb begin
    word_q_valid = i_data_valid && i_sync;
    in_seq_d     = 1'b0;
    seq_err_d    = 1'b0;
    if (word_q_valid && state_q == S_COLLECT) begin
      in_seq_d  = (i_channel == expected_q);
      seq_err_d = (i_channel != expected_q);
    end
    last_d    = in_seq_d && (expected_q == 3'd7);
    publish_d = last_d && (!frame_valid_q || i_frame_ready);
    overrun_d = last_d && frame_valid_q && !i_frame_ready;
  end

`ifdef ADAT_RX_FRAME_CNT_EN
  logic [15:0] frame_count_q;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) frame_count_q <= '0;
    else if (publish_d) frame_count_q <= frame_count_q + 16'd1;
  end
  assign o_frame_count = frame_count_q;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= S_IDLE;
      expected_q    <= '0;
      user_cap_q    <= '0;
      samples_q     <= '0;
      user_q        <= '0;
      frame_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
      seq_err_q     <= 1'b0;
      for (int i = 0; i < 8; i++) shadow_q[i] <= '0;
    end else begin
      overrun_q <= overrun_d;
      seq_err_q <= seq_err_d;

      if (publish_d) begin
        samples_q     <= frame_word;
        user_q        <= user_cap_q;
        frame_valid_q <= 1'b1;
      end else if (frame_valid_q && i_frame_ready) begin
        frame_valid_q <= 1'b0;
      end

      // Loss of lock abandons the partial frame; the published frame is untouched.
      if (!i_sync) begin
        state_q    <= S_IDLE;
        expected_q <= '0;
      end else if (i_data_valid) begin
        if (in_seq_d) begin
          shadow_q[expected_q] <= i_data;
          if (expected_q == 3'd7) begin
            state_q    <= S_IDLE;
            expected_q <= '0;
          end else begin
            expected_q <= expected_q + 3'd1;
          end
        end else if (i_channel == 3'd0) begin
          shadow_q[0] <= i_data;
          user_cap_q  <= i_user;
          expected_q  <= 3'd1;
          state_q     <= S_COLLECT;
        end else if (state_q == S_COLLECT) begin
          state_q <= S_DISCARD;
        end
      end
    end
  end

  assign o_samples     = samples_q;
  assign o_user        = user_q;
  assign o_frame_valid = frame_valid_q;
  assign o_overrun     = overrun_q;
  assign o_seq_err     = seq_err_q;

endmodule
